// File: rtl/itcm_fetch_arbiter.sv
// ---------------------------------------------------------------------------
// itcm_fetch_arbiter
//
// Shares the single instruction-memory fetch port among NUM_REQ requesters
// (e.g. icache refill adapter, prefetch/debug fetcher). A round-robin arbiter
// selects one pending requester and loads it into a registered request stage.
// A credit counter limits the number of issued-but-unacknowledged fetches.
// The winning requester index is prepended to the entry id so that memory acks,
// which may return out of order, are routed back to the requester that issued
// them.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req_vld/req_rdy          per-requester request handshake (req_rdy one-hot or 0)
//   req_addr, req_id         packed per-requester address / entry id
//   mem_req_vld/mem_req_rdy  registered request towards memory
//   mem_req_addr, mem_req_id registered address and {src_index, entry id}
//   mem_ack_vld/mem_ack_rdy  ack handshake from memory
//   mem_ack_data, mem_ack_id ack payload and echoed {src_index, entry id}
//   ack_vld/ack_rdy          per-requester ack handshake (only bit [src] set)
//   ack_data, ack_id         ack payload broadcast to all requesters
//   err_bad_src              sticky: ack with unknown source or without credit
// ---------------------------------------------------------------------------
module itcm_fetch_arbiter #(
   parameter int  NUM_REQ         = 2,
   parameter int  ADDR_WIDTH      = 32,
   parameter int  DATA_WIDTH      = 256,
   parameter int  ID_WIDTH        = 16,
   parameter int  MAX_OUTSTANDING = 4,
   localparam int SEL_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
   localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_vld,
   output logic [NUM_REQ-1:0]            req_rdy,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*ID_WIDTH-1:0]   req_id,
   output logic                          mem_req_vld,
   input  logic                          mem_req_rdy,
   output logic [ADDR_WIDTH-1:0]         mem_req_addr,
   output logic [SEL_W+ID_WIDTH-1:0]     mem_req_id,
   input  logic                          mem_ack_vld,
   output logic                          mem_ack_rdy,
   input  logic [DATA_WIDTH-1:0]         mem_ack_data,
   input  logic [SEL_W+ID_WIDTH-1:0]     mem_ack_id,
   output logic [NUM_REQ-1:0]            ack_vld,
   input  logic [NUM_REQ-1:0]            ack_rdy,
   output logic [DATA_WIDTH-1:0]         ack_data,
   output logic [ID_WIDTH-1:0]           ack_id,
   output logic                          err_bad_src
);

   logic [SEL_W-1:0]      rr_ptr;
   logic [CNT_W-1:0]      out_cnt;

   logic                  slot_free;
   logic                  credit_ok;
   logic                  arb_en;
   logic                  grant_any;
   logic                  grant_fire;
   logic [SEL_W-1:0]      grant_idx;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [ID_WIDTH-1:0]   sel_id;
   int                    scan_idx;

   logic [SEL_W-1:0]      ack_src;
   logic                  src_ok;
   logic                  ack_hs;

   // The stage can take a new request when empty or when it drains this cycle.
   // rst is folded in so that no handshake is offered while reset is held.
   assign slot_free = !mem_req_vld || mem_req_rdy;
   assign credit_ok = out_cnt < CNT_W'(MAX_OUTSTANDING);
   assign arb_en    = !rst && slot_free && credit_ok;

   // Round-robin scan starting at rr_ptr, wrapping at NUM_REQ.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      sel_addr  = '0;
      sel_id    = '0;
      scan_idx  = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_idx = int'(rr_ptr) + k;
         if (scan_idx >= NUM_REQ) begin
            scan_idx = scan_idx - NUM_REQ;
         end
         if (!grant_any && req_vld[scan_idx]) begin
            grant_any = 1'b1;
            grant_idx = SEL_W'(scan_idx);
            sel_addr  = req_addr[scan_idx*ADDR_WIDTH +: ADDR_WIDTH];
            sel_id    = req_id[scan_idx*ID_WIDTH +: ID_WIDTH];
         end
      end
   end

   // A selected requester always has req_vld set, so offering ready is the handshake.
   assign grant_fire = arb_en && grant_any;

   always_comb begin
      req_rdy = '0;
      if (grant_fire) begin
         req_rdy[grant_idx] = 1'b1;
      end
   end

   // Request stage register: reloads on a grant, otherwise drains on mem_req_rdy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_req_vld  <= 1'b0;
         mem_req_addr <= '0;
         mem_req_id   <= '0;
         rr_ptr       <= '0;
      end else if (grant_fire) begin
         mem_req_vld  <= 1'b1;
         mem_req_addr <= sel_addr;
         mem_req_id   <= {grant_idx, sel_id};
         rr_ptr       <= (grant_idx == SEL_W'(NUM_REQ - 1)) ? '0 : grant_idx + SEL_W'(1);
      end else if (mem_req_rdy) begin
         mem_req_vld  <= 1'b0;
      end
   end

   // Ack routing: the upper SEL_W id bits name the requester. Unknown sources
   // are swallowed (ready forced high) so memory is never blocked by them.
   assign ack_src = mem_ack_id[SEL_W+ID_WIDTH-1 -: SEL_W];
   assign src_ok  = {1'b0, ack_src} < (SEL_W + 1)'(NUM_REQ);

   always_comb begin
      ack_vld     = '0;
      mem_ack_rdy = 1'b1;
      if (src_ok) begin
         ack_vld[ack_src] = mem_ack_vld;
         mem_ack_rdy      = ack_rdy[ack_src];
      end
   end

   assign ack_hs   = mem_ack_vld && mem_ack_rdy;
   assign ack_data = mem_ack_data;
   assign ack_id   = mem_ack_id[ID_WIDTH-1:0];

   // Outstanding count includes the request still sitting in the stage.
   // An ack without credit cannot be matched to anything: flag it, floor at 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_cnt     <= '0;
         err_bad_src <= 1'b0;
      end else begin
         if (grant_fire && !ack_hs) begin
            out_cnt <= out_cnt + CNT_W'(1);
         end else if (!grant_fire && ack_hs && (out_cnt != '0)) begin
            out_cnt <= out_cnt - CNT_W'(1);
         end
         if (ack_hs && (!src_ok || (out_cnt == '0))) begin
            err_bad_src <= 1'b1;
         end
      end
   end

endmodule
